// File: rtl/z80_bus_pkg.sv
`default_nettype none
//==============================================================================
// Module   : z80_bus_pkg
// Purpose  : Shared types and default window constants for Z80 bus bridges.
// Revision : 1.0 - initial release
//==============================================================================
package z80_bus_pkg;

   localparam int          c_def_addr_w    = 14;
   localparam int          c_def_data_w    = 8;
   localparam logic [15:0] c_def_base_addr = 16'h4000;
   localparam int          c_wait_w        = 4;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      RD_ISSUE   = 3'd1,
      RD_CAPTURE = 3'd2,
      RD_STALL   = 3'd3,
      WR_ISSUE   = 3'd4,
      HOLD       = 3'd5
   } bridge_state_t;

   typedef struct packed {
      logic                    mreq_n;
      logic                    rd_n;
      logic                    wr_n;
      logic [15:0]             addr;
      logic [c_def_data_w-1:0] wdata;
   } bus_req_t;

endpackage
`default_nettype wire

// File: rtl/wait_counter.sv
`default_nettype none
//==============================================================================
// Module   : wait_counter
// Purpose  : Loadable down-counter flagging the last stall cycle of a read.
// Revision : 1.0 - initial release
//==============================================================================
module wait_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= load_val;
      end else if (en && (r_count != '0)) begin
         r_count <= r_count - W'(1);
      end
   end

   // A count of one marks the final stall cycle.
   assign done = (r_count == W'(1));

endmodule
`default_nettype wire

// File: rtl/z80_ram_bridge.sv
`default_nettype none
//==============================================================================
// Module   : z80_ram_bridge
// Purpose  : Z80 memory-bus to synchronous single-port RAM bridge.
// Revision : 1.0 - initial release
//==============================================================================
module z80_ram_bridge
   import z80_bus_pkg::*;
#(
   parameter int          ADDR_W     = c_def_addr_w,
   parameter int          DATA_W     = c_def_data_w,
   parameter logic [15:0] BASE_ADDR  = c_def_base_addr,
   parameter int          EXTRA_WAIT = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mreq_n,
   input  logic              rd_n,
   input  logic              wr_n,
   input  logic [15:0]       cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_sel,
   output logic              wait_n,
   output logic              ram_ena,
   output logic              ram_rd,
   output logic              ram_wr,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              bus_err
);

   bridge_state_t     r_state;
   logic              r_ram_ena;
   logic              r_ram_rd;
   logic              r_ram_wr;
   logic              r_bus_err;
   logic [ADDR_W-1:0] r_ram_addr;
   logic [DATA_W-1:0] r_ram_din;
   logic [DATA_W-1:0] r_cpu_rdata;

   logic              w_hit;
   logic              w_rd_req;
   logic              w_wr_req;
   logic              w_both_req;
   logic              w_release;
   logic              w_cnt_done;

   generate
      if (ADDR_W >= 16) begin : g_full_window
         assign w_hit = 1'b1;
      end else begin : g_part_window
         assign w_hit = (cpu_addr[15:ADDR_W] == BASE_ADDR[15:ADDR_W]);
      end
   endgenerate

   assign w_rd_req   = !mreq_n && !rd_n &&  wr_n && w_hit;
   assign w_wr_req   = !mreq_n && !wr_n &&  rd_n && w_hit;
   assign w_both_req = !mreq_n && !rd_n && !wr_n && w_hit;
   assign w_release  = mreq_n || (rd_n && wr_n);

   generate
      if (EXTRA_WAIT > 0) begin : g_wait
         localparam logic [c_wait_w-1:0] c_extra = c_wait_w'(EXTRA_WAIT);

         wait_counter #(
            .W(c_wait_w)
         ) u_wait_counter (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (r_state == RD_CAPTURE),
            .en       (r_state == RD_STALL),
            .load_val (c_extra),
            .done     (w_cnt_done)
         );
      end else begin : g_no_wait
         assign w_cnt_done = 1'b1;
      end
   endgenerate

   // RAM strobes default low so each access pulses for exactly one cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_ram_ena   <= 1'b0;
         r_ram_rd    <= 1'b0;
         r_ram_wr    <= 1'b0;
         r_ram_addr  <= '0;
         r_ram_din   <= '0;
         r_cpu_rdata <= '0;
         r_bus_err   <= 1'b0;
      end else begin
         r_ram_ena <= 1'b0;
         r_ram_rd  <= 1'b0;
         r_ram_wr  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_rd_req) begin
                  r_state    <= RD_ISSUE;
                  r_ram_ena  <= 1'b1;
                  r_ram_rd   <= 1'b1;
                  r_ram_addr <= cpu_addr[ADDR_W-1:0];
               end else if (w_wr_req) begin
                  r_state    <= WR_ISSUE;
                  r_ram_ena  <= 1'b1;
                  r_ram_wr   <= 1'b1;
                  r_ram_addr <= cpu_addr[ADDR_W-1:0];
                  r_ram_din  <= cpu_wdata;
               end else if (w_both_req) begin
                  r_bus_err  <= 1'b1;
               end
            end
            RD_ISSUE: begin
               r_state <= RD_CAPTURE;
            end
            RD_CAPTURE: begin
               r_cpu_rdata <= ram_dout;
               if (EXTRA_WAIT == 0) begin
                  r_state <= HOLD;
               end else begin
                  r_state <= RD_STALL;
               end
            end
            RD_STALL: begin
               if (w_cnt_done) begin
                  r_state <= HOLD;
               end
            end
            WR_ISSUE: begin
               r_state <= HOLD;
            end
            HOLD: begin
               if (w_release) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign wait_n = !((r_state == IDLE && w_rd_req) ||
                     (r_state == RD_ISSUE) ||
                     (r_state == RD_CAPTURE) ||
                     (r_state == RD_STALL));

   assign cpu_sel   = !mreq_n && w_hit;
   assign cpu_rdata = r_cpu_rdata;
   assign ram_ena   = r_ram_ena;
   assign ram_rd    = r_ram_rd;
   assign ram_wr    = r_ram_wr;
   assign ram_addr  = r_ram_addr;
   assign ram_din   = r_ram_din;
   assign bus_err   = r_bus_err;

endmodule
`default_nettype wire
